sccb_target_regfile: RTL and testbench

//  SCCB/I2C target (slave) that answers the camera-config master: decodes 3-phase

---
 rtl/sccb_pkg.sv | 21 ++
 rtl/sccb_line_sync.sv | 45 ++++
 rtl/sccb_target_regfile.sv | 212 +++++++++++++++++++++
 tb/tb_sccb_target_regfile.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB target register file.
// FSM states, byte geometry and the default device address.
package sccb_pkg;

  localparam int         BYTE_BITS     = 8;
  localparam int         SCCB_RD_BIT   = 0;
  localparam logic [7:0] SCCB_DEF_ADDR = 8'h42;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEVA,
    S_DEVA_ACK,
    S_SUBA,
    S_SUBA_ACK,
    S_WDAT,
    S_WDAT_ACK,
    S_RDAT,
    S_RDAT_MACK
  } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP detection.
// All events are single-cycle pulses on the synchronized lines.
module sccb_line_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_LEN-1:0] scl_q;
  logic [SYNC_LEN-1:0] sda_q;
  logic                scl_p_q;
  logic                sda_p_q;
  logic                scl_s;

  // Idle bus is high; resetting to 1 avoids phantom edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q   <= '1;
      sda_q   <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_q   <= {scl_q[SYNC_LEN-2:0], scl_i};
      sda_q   <= {sda_q[SYNC_LEN-2:0], sda_i};
      scl_p_q <= scl_q[SYNC_LEN-1];
      sda_p_q <= sda_q[SYNC_LEN-1];
    end
  end

  assign scl_s      = scl_q[SYNC_LEN-1];
  assign sda_o      = sda_q[SYNC_LEN-1];
  assign scl_rise_o = scl_s & ~scl_p_q;
  assign scl_fall_o = ~scl_s & scl_p_q;
  assign start_o    = scl_s & scl_p_q & sda_p_q & ~sda_o;
  assign stop_o     = scl_s & scl_p_q & ~sda_p_q & sda_o;

endmodule

// File: rtl/sccb_target_regfile.sv
// SCCB target backed by a 256x8 register file.
// Accepts 3-phase writes and 2-phase-write + read sequences.
module sccb_target_regfile
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = SCCB_DEF_ADDR,
  parameter int         SYNC_LEN = 2,
  parameter int         CNT_W    = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             I2C_SCLK,
  inout  wire              I2C_SDAT,
  input  logic [7:0]       iRD_ADDR,
  output logic [7:0]       oRD_DATA,
  output logic             oWR_STB,
  output logic [7:0]       oWR_ADDR,
  output logic [7:0]       oWR_DATA,
  output logic [CNT_W-1:0] oWR_CNT,
  output logic             oBUSY
);

  localparam logic [7:0] RD_ADDR = DEV_ADDR | 8'(1 << SCCB_RD_BIT);
  localparam logic [3:0] NBITS   = 4'(BYTE_BITS);

  logic sda_s, rise, fall, start, stop;

  sccb_line_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .scl_i     (I2C_SCLK),
    .sda_i     (I2C_SDAT),
    .sda_o     (sda_s),
    .scl_rise_o(rise),
    .scl_fall_o(fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  sccb_state_e      state_q, state_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       ptr_q, ptr_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             stb_q, stb_d;
  logic [7:0]       wa_q, wa_d;
  logic [7:0]       wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rd_q;
  logic             we;
  logic [7:0]       mem_q [256];
  logic [7:0]       cur;

  assign cur = mem_q[ptr_q];

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = S_DEVA;
      bcnt_d  = '0;
      oe_d    = 1'b0;
    end else if (rise) begin
      case (state_q)
        S_DEVA, S_SUBA, S_WDAT: begin
          if (bcnt_q < NBITS) begin
            sh_d   = {sh_q[6:0], sda_s};
            bcnt_d = bcnt_q + 4'd1;
          end
        end
        S_RDAT: bcnt_d = bcnt_q + 4'd1;
        // Master ack bit; ptr advances whether acked or not.
        S_RDAT_MACK: begin
          ptr_d = ptr_q + 8'd1;
          if (sda_s) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            bcnt_d = 4'd1;
          end
        end
        default: ;
      endcase
    end else if (fall) begin
      case (state_q)
        S_DEVA: begin
          if (bcnt_q == NBITS) begin
            bcnt_d = '0;
            if (sh_q == DEV_ADDR || sh_q == RD_ADDR) begin
              state_d = S_DEVA_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        S_SUBA: begin
          if (bcnt_q == NBITS) begin
            ptr_d   = sh_q;
            bcnt_d  = '0;
            oe_d    = 1'b1;
            state_d = S_SUBA_ACK;
          end
        end
        S_WDAT: begin
          if (bcnt_q == NBITS) begin
            we      = 1'b1;
            stb_d   = 1'b1;
            wa_d    = ptr_q;
            wd_d    = sh_q;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            ptr_d   = ptr_q + 8'd1;
            bcnt_d  = '0;
            oe_d    = 1'b1;
            state_d = S_WDAT_ACK;
          end
        end
        S_DEVA_ACK: begin
          if (sh_q[SCCB_RD_BIT]) begin
            sh_d    = cur;
            oe_d    = ~cur[7];
            state_d = S_RDAT;
          end else begin
            oe_d    = 1'b0;
            state_d = S_SUBA;
          end
        end
        S_SUBA_ACK, S_WDAT_ACK: begin
          oe_d    = 1'b0;
          state_d = S_WDAT;
        end
        S_RDAT: begin
          if (bcnt_q == NBITS) begin
            oe_d    = 1'b0;
            bcnt_d  = '0;
            state_d = S_RDAT_MACK;
          end else begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = ~sh_q[6];
          end
        end
        S_RDAT_MACK: begin
          if (bcnt_q != 4'd0) begin
            sh_d    = cur;
            oe_d    = ~cur[7];
            bcnt_d  = '0;
            state_d = S_RDAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      rd_q    <= mem_q[iRD_ADDR];
    end
  end

  // Register contents survive reset.
  always_ff @(posedge iCLK) begin
    if (we) mem_q[ptr_q] <= sh_q;
  end

  assign I2C_SDAT = oe_q ? 1'b0 : 1'bz;
  assign oRD_DATA = rd_q;
  assign oWR_STB  = stb_q;
  assign oWR_ADDR = wa_q;
  assign oWR_DATA = wd_q;
  assign oWR_CNT  = cnt_q;
  assign oBUSY    = busy_q;

endmodule

// File: tb/tb_sccb_target_regfile.sv
// Bench for sccb_target_regfile: bus master tasks plus a
// transaction-level register-file model.
module tb_sccb_target_regfile;

  localparam int Q = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic [7:0]  rd_addr = 8'h00;
  logic [7:0]  rd_data, wr_addr, wr_data;
  logic        wr_stb, busy;
  logic [15:0] wr_cnt;
  wire         sda;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_m [256];
  bit         val_m [256];
  logic [7:0] ptr_m = 8'h00;
  int         cnt_m = 0;
  int         stb_n = 0;
  bit         busy_seen = 0;
  logic [7:0] wd [$];
  logic [7:0] addrs [$];

  bit         rbw_en = 0;
  bit         rbw_pend = 0;
  logic [7:0] rbw_old, rbw_new;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  sccb_target_regfile dut (
    .iCLK    (clk),
    .iRST    (rst),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda),
    .iRD_ADDR(rd_addr),
    .oRD_DATA(rd_data),
    .oWR_STB (wr_stb),
    .oWR_ADDR(wr_addr),
    .oWR_DATA(wr_data),
    .oWR_CNT (wr_cnt),
    .oBUSY   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_stb) stb_n++;
    if (busy) busy_seen = 1;
  end

  always @(negedge clk) begin
    if (rbw_pend) begin
      chk("rbw_new", rd_data, rbw_new);
      rbw_pend = 0;
    end else if (rbw_en && wr_stb) begin
      chk("rbw_old", rd_data, rbw_old);
      rbw_pend = 1;
      rbw_en = 0;
    end
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
  endtask

  task automatic m_start();
    m_low = 1'b0; wq();
    scl = 1'b1; wq();
    m_low = 1'b1; wq();
    scl = 1'b0; wq();
  endtask

  task automatic m_stop();
    m_low = 1'b1; wq();
    scl = 1'b1; wq();
    m_low = 1'b0; wq(); wq();
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_low = ~b; wq();
    scl = 1'b1; wq();
    r = sda; wq();
    scl = 1'b0; wq();
  endtask

  task automatic m_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    m_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic m_rd(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(~mack, r);
  endtask

  task automatic model_wr(input logic [7:0] d);
    mem_m[ptr_m] = d;
    val_m[ptr_m] = 1;
    addrs.push_back(ptr_m);
    ptr_m++;
    if (cnt_m < 65535) cnt_m++;
  endtask

  task automatic wr_txn(input logic [7:0] dev, input logic [7:0] sub,
                        input string tag);
    logic a;
    bit m;
    int s0;
    logic [7:0] la;
    m = (dev == 8'h42);
    s0 = stb_n;
    m_start();
    m_byte(dev, a); chk({tag, "_ackd"}, a, m);
    m_byte(sub, a); chk({tag, "_acks"}, a, m);
    if (m) ptr_m = sub;
    foreach (wd[i]) begin
      m_byte(wd[i], a); chk({tag, "_ackw"}, a, m);
      if (m) model_wr(wd[i]);
    end
    m_stop();
    chk({tag, "_stb"}, stb_n - s0, m ? wd.size() : 0);
    chk({tag, "_cnt"}, wr_cnt, cnt_m);
    if (m && wd.size() > 0) begin
      la = ptr_m - 8'd1;
      chk({tag, "_wa"}, wr_addr, la);
      chk({tag, "_wd"}, wr_data, wd[wd.size()-1]);
    end
  endtask

  task automatic rd_txn(input bit set_sub, input logic [7:0] sub,
                        input bit rep, input int n, input string tag);
    logic a;
    logic [7:0] d;
    if (set_sub) begin
      m_start();
      m_byte(8'h42, a); chk({tag, "_ackd"}, a, 1);
      m_byte(sub, a); chk({tag, "_acks"}, a, 1);
      ptr_m = sub;
      if (!rep) m_stop();
    end
    m_start();
    m_byte(8'h43, a); chk({tag, "_ackr"}, a, 1);
    for (int k = 0; k < n; k++) begin
      m_rd(k < n - 1, d);
      if (val_m[ptr_m]) chk({tag, "_rd"}, d, mem_m[ptr_m]);
      ptr_m++;
    end
    chk({tag, "_rel"}, sda, 1);
    chk({tag, "_idle"}, busy, 0);
    m_stop();
  endtask

  task automatic host_chk(input logic [7:0] ad, input string tag);
    @(negedge clk);
    rd_addr = ad;
    @(posedge clk);
    @(negedge clk);
    if (val_m[ad]) chk(tag, rd_data, mem_m[ad]);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic a, r;
    logic [7:0] b, dev, sub;
    int op, n, s0;

    repeat (4) @(negedge clk);
    chk("rst_stb", wr_stb, 0);
    chk("rst_cnt", wr_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_sda", sda, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    wd = {8'h04};
    wr_txn(8'h42, 8'h3A, "t1");
    host_chk(8'h3A, "t1_host");

    rbw_old = 8'h04;
    rbw_new = 8'($urandom);
    rd_addr = 8'h3A;
    rbw_en = 1;
    wd = {rbw_new};
    wr_txn(8'h42, 8'h3A, "rbw");
    rbw_en = 0;

    busy_seen = 0;
    wd = {8'h04};
    wr_txn(8'h60, 8'h3A, "t2");
    chk("t2_busy", busy_seen, 0);
    host_chk(8'h3A, "t2_host");

    wd = {8'h76, 8'($urandom)};
    wr_txn(8'h42, 8'h0A, "t3w");
    rd_txn(1, 8'h0A, 0, 1, "t3");
    rd_txn(0, 8'h00, 0, 1, "t3p");

    wd = {8'hAA, 8'hBB};
    wr_txn(8'h42, 8'hFF, "t4");
    host_chk(8'hFF, "t4_ff");
    host_chk(8'h00, "t4_00");

    s0 = stb_n;
    m_start();
    m_byte(8'h42, a);
    m_byte(8'h3A, a);
    for (int i = 0; i < 5; i++) m_bit(1'($urandom), r);
    m_stop();
    chk("t5_nostb", stb_n - s0, 0);
    host_chk(8'h3A, "t5_keep");
    m_start();
    m_byte(8'h42, a);
    m_byte(8'h3A, a);
    m_start();
    m_byte(8'h42, a);
    m_byte(8'h3B, a);
    m_byte(8'h55, a); chk("t5_ack", a, 1);
    ptr_m = 8'h3B;
    model_wr(8'h55);
    m_stop();
    chk("t5_stb", stb_n - s0, 1);
    host_chk(8'h3A, "t5_3a");
    host_chk(8'h3B, "t5_3b");

    b = 8'h42;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_low = 1'b0; wq();
    scl = 1'b1; wq();
    chk("t6_ackdrv", sda, 0);
    #1 rst = 1'b1;
    #1;
    chk("t6_sda", sda, 1);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", wr_cnt, 0);
    chk("t6_wa", wr_addr, 0);
    chk("t6_wd", wr_data, 0);
    chk("t6_rd", rd_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    wq();
    scl = 1'b0; wq();
    m_stop();
    host_chk(8'h3B, "t6_keep");
    wd = {8'h99};
    wr_txn(8'h42, 8'h10, "t6n");
    host_chk(8'h10, "t6_host");

    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      if (op <= 1) begin
        dev = 8'h42;
        if ($urandom_range(0, 4) == 0) begin
          dev = 8'($urandom);
          if (dev[7:1] == 7'h21) dev = dev ^ 8'h80;
        end
        sub = 8'($urandom);
        wd.delete();
        repeat (n) wd.push_back(8'($urandom));
        wr_txn(dev, sub, "rw");
      end else if (op == 2) begin
        sub = addrs[$urandom_range(0, addrs.size() - 1)];
        rd_txn(1, sub, 1'($urandom_range(0, 1)), n, "rr");
      end else begin
        sub = addrs[$urandom_range(0, addrs.size() - 1)];
        host_chk(sub, "rh");
      end
    end
    chk("end_cnt", wr_cnt, cnt_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
